// File: rtl/cp0_regfile.sv
// MIPS32 coprocessor-0 register file: BadVAddr, Count/Compare timer, Status, Cause, EPC.
// Exception commit beats ERET, which beats MTC0; Count/Compare writes never conflict.
module cp0_regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mtc0_we,
    input  logic [4:0]  mtc0_addr,
    input  logic [31:0] mtc0_wdata,
    input  logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    input  logic        exc_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_epc,
    input  logic        exc_bd,
    input  logic        exc_badvaddr_we,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret,
    input  logic [5:0]  hw_int,
    output logic [31:0] status,
    output logic [31:0] cause,
    output logic [31:0] epc,
    output logic        int_pending
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    logic [31:0] badvaddr_reg;
    logic [31:0] count_reg;
    logic        toggle_reg;
    logic [31:0] compare_reg;
    logic [31:0] epc_reg;
    logic [7:0]  im_reg;
    logic        exl_reg;
    logic        ie_reg;
    logic        bd_reg;
    logic        ti_reg;
    logic [5:0]  ip_hw_reg;
    logic [1:0]  ip_sw_reg;
    logic [4:0]  exc_code_reg;

    logic wr_badvaddr;
    logic wr_count;
    logic wr_compare;
    logic wr_status;
    logic wr_cause;
    logic wr_epc;

    // MTC0 strobes, with writes dropped when a higher-priority commit owns the register
    always_comb begin
        wr_badvaddr = mtc0_we && (mtc0_addr == REG_BADVADDR) && !exc_valid;
        wr_count    = mtc0_we && (mtc0_addr == REG_COUNT);
        wr_compare  = mtc0_we && (mtc0_addr == REG_COMPARE);
        wr_status   = mtc0_we && (mtc0_addr == REG_STATUS) && !exc_valid && !eret;
        wr_cause    = mtc0_we && (mtc0_addr == REG_CAUSE) && !exc_valid;
        wr_epc      = mtc0_we && (mtc0_addr == REG_EPC) && !exc_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            badvaddr_reg <= '0;
        end else if (exc_valid && exc_badvaddr_we) begin
            badvaddr_reg <= exc_badvaddr;
        end else if (wr_badvaddr) begin
            badvaddr_reg <= mtc0_wdata;
        end
    end

    // Count advances on every second edge; a software load restarts the half-rate phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg  <= '0;
            toggle_reg <= 1'b0;
        end else if (wr_count) begin
            count_reg  <= mtc0_wdata;
            toggle_reg <= 1'b0;
        end else begin
            toggle_reg <= ~toggle_reg;
            if (toggle_reg) begin
                count_reg <= count_reg + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            compare_reg <= '0;
            ti_reg      <= 1'b0;
        end else if (wr_compare) begin
            compare_reg <= mtc0_wdata;
            ti_reg      <= 1'b0;
        end else if (count_reg == compare_reg) begin
            ti_reg      <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            im_reg  <= '0;
            exl_reg <= 1'b0;
            ie_reg  <= 1'b0;
        end else if (exc_valid) begin
            exl_reg <= 1'b1;
        end else if (eret) begin
            exl_reg <= 1'b0;
        end else if (wr_status) begin
            im_reg  <= mtc0_wdata[15:8];
            exl_reg <= mtc0_wdata[1];
            ie_reg  <= mtc0_wdata[0];
        end
    end

    // A nested exception (EXL already set) keeps the original EPC and BD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bd_reg       <= 1'b0;
            exc_code_reg <= '0;
            ip_sw_reg    <= '0;
            epc_reg      <= '0;
        end else if (exc_valid) begin
            exc_code_reg <= exc_code;
            if (!exl_reg) begin
                bd_reg  <= exc_bd;
                epc_reg <= exc_epc;
            end
        end else begin
            if (wr_cause) begin
                ip_sw_reg <= mtc0_wdata[9:8];
            end
            if (wr_epc) begin
                epc_reg <= mtc0_wdata;
            end
        end
    end

    // The timer interrupt shares IP7 with hw_int[5]
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ip_hw_reg <= '0;
        end else begin
            ip_hw_reg <= {hw_int[5] | ti_reg, hw_int[4:0]};
        end
    end

    always_comb begin
        status = {9'b0, 1'b1, 6'b0, im_reg, 6'b0, exl_reg, ie_reg};
        cause  = {bd_reg, ti_reg, 14'b0, ip_hw_reg, ip_sw_reg, 1'b0, exc_code_reg, 2'b0};
        epc    = epc_reg;
        int_pending = (|(cause[15:8] & status[15:8])) & ie_reg & ~exl_reg;
    end

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            REG_BADVADDR: rd_data = badvaddr_reg;
            REG_COUNT:    rd_data = count_reg;
            REG_COMPARE:  rd_data = compare_reg;
            REG_STATUS:   rd_data = status;
            REG_CAUSE:    rd_data = cause;
            REG_EPC:      rd_data = epc_reg;
            default:      rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// Scoreboard bench for cp0_regfile: expectations are queued with each stimulus and
// compared when the corresponding output is observed.
module tb_cp0_regfile;

    logic        clk;
    logic        rst_n;
    logic        mtc0_we;
    logic [4:0]  mtc0_addr;
    logic [31:0] mtc0_wdata;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_epc;
    logic        exc_bd;
    logic        exc_badvaddr_we;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic [5:0]  hw_int;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        int_pending;

    int total = 0;
    int bad   = 0;

    // Observation points: 0..31 are MFC0 reads, the rest are direct outputs/fields
    localparam logic [5:0] OBS_INTP  = 6'd32;
    localparam logic [5:0] OBS_EPC   = 6'd33;
    localparam logic [5:0] OBS_STAT  = 6'd34;
    localparam logic [5:0] OBS_CAUSE = 6'd35;
    localparam logic [5:0] OBS_TI    = 6'd36;
    localparam logic [5:0] OBS_IP7   = 6'd37;

    logic [5:0]  q_addr[$];
    logic [31:0] q_val[$];
    string       q_tag[$];

    cp0_regfile dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mtc0_we         (mtc0_we),
        .mtc0_addr       (mtc0_addr),
        .mtc0_wdata      (mtc0_wdata),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .exc_valid       (exc_valid),
        .exc_code        (exc_code),
        .exc_epc         (exc_epc),
        .exc_bd          (exc_bd),
        .exc_badvaddr_we (exc_badvaddr_we),
        .exc_badvaddr    (exc_badvaddr),
        .eret            (eret),
        .hw_int          (hw_int),
        .status          (status),
        .cause           (cause),
        .epc             (epc),
        .int_pending     (int_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end else begin
            $display("[%0t] %s: %08h ok", $time, tag, got);
        end
    endtask

    task automatic expect_val(input string tag, input logic [5:0] a, input logic [31:0] v);
        q_tag.push_back(tag);
        q_addr.push_back(a);
        q_val.push_back(v);
    endtask

    task automatic drain();
        logic [5:0]  a;
        logic [31:0] v;
        logic [31:0] got;
        string       t;
        while (q_addr.size() > 0) begin
            a = q_addr.pop_front();
            v = q_val.pop_front();
            t = q_tag.pop_front();
            if (a < 6'd32) rd_addr = a[4:0];
            #1;
            case (a)
                OBS_INTP:  got = {31'b0, int_pending};
                OBS_EPC:   got = epc;
                OBS_STAT:  got = status;
                OBS_CAUSE: got = cause;
                OBS_TI:    got = {31'b0, cause[30]};
                OBS_IP7:   got = {31'b0, cause[15]};
                default:   got = rd_data;
            endcase
            check_val(t, got, v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        mtc0_we    = 1'b1;
        mtc0_addr  = a;
        mtc0_wdata = d;
        step();
        mtc0_we    = 1'b0;
    endtask

    task automatic do_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                          input logic bwe, input logic [31:0] bva, input logic er);
        exc_valid       = 1'b1;
        exc_code        = code;
        exc_epc         = pc;
        exc_bd          = bd;
        exc_badvaddr_we = bwe;
        exc_badvaddr    = bva;
        eret            = er;
        step();
        exc_valid       = 1'b0;
        exc_badvaddr_we = 1'b0;
        eret            = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        mtc0_we = 1'b0; mtc0_addr = '0; mtc0_wdata = '0; rd_addr = '0;
        exc_valid = 1'b0; exc_code = '0; exc_epc = '0; exc_bd = 1'b0;
        exc_badvaddr_we = 1'b0; exc_badvaddr = '0; eret = 1'b0; hw_int = '0;

        #2 rst_n = 1'b0;
        expect_val("rst_status", OBS_STAT, 32'h0040_0000);
        expect_val("rst_cause", OBS_CAUSE, 32'h0);
        expect_val("rst_intp", OBS_INTP, 32'h0);
        drain();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Move Compare away so the post-reset timer hit clears out of TI and IP7
        mtc0(5'd11, 32'hFFFF_0000);
        step();
        expect_val("ti_cleared", OBS_CAUSE, 32'h0);
        drain();

        mtc0(5'd12, 32'hFFFF_FFFF);
        expect_val("status_mask", 6'd12, 32'h0040_FF03);
        drain();
        mtc0(5'd13, 32'hFFFF_FFFF);
        expect_val("cause_mask", 6'd13, 32'h0000_0300);
        expect_val("intp_exl_blocks", OBS_INTP, 32'h0);
        drain();
        mtc0(5'd15, 32'hFFFF_FFFF);
        expect_val("reg15_reads0", 6'd15, 32'h0);
        drain();
        mtc0(5'd12, 32'h0040_0000);
        mtc0(5'd13, 32'h0);

        do_exc(5'h04, 32'hBFC0_0104, 1'b1, 1'b1, 32'hBFC0_0101, 1'b0);
        expect_val("exc1_epc", 6'd14, 32'hBFC0_0104);
        expect_val("exc1_cause", 6'd13, 32'h8000_0010);
        expect_val("exc1_status", 6'd12, 32'h0040_0002);
        expect_val("exc1_badva", 6'd8, 32'hBFC0_0101);
        drain();
        do_exc(5'h0C, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 1'b0);
        expect_val("exc2_epc", 6'd14, 32'hBFC0_0104);
        expect_val("exc2_cause", 6'd13, 32'h8000_0030);
        expect_val("exc2_badva", 6'd8, 32'hBFC0_0101);
        drain();

        do_exc(5'h08, 32'h0000_0040, 1'b0, 1'b0, 32'h0, 1'b1);
        expect_val("exc_eret_status", OBS_STAT, 32'h0040_0002);
        expect_val("exc_eret_cause", OBS_CAUSE, 32'h8000_0020);
        drain();
        eret = 1'b1;
        step();
        eret = 1'b0;
        expect_val("eret_status", OBS_STAT, 32'h0040_0000);
        expect_val("eret_epc", OBS_EPC, 32'hBFC0_0104);
        drain();

        // Count=0 then Compare=10: count hits 10 twenty edges after the Count write
        mtc0(5'd9, 32'h0);
        mtc0(5'd11, 32'd10);
        for (int i = 0; i < 19; i++) step();
        expect_val("ti_before", OBS_TI, 32'h0);
        expect_val("count_at10", 6'd9, 32'd10);
        drain();
        step();
        expect_val("ti_set", OBS_TI, 32'h1);
        expect_val("ip7_lag", OBS_IP7, 32'h0);
        drain();
        step();
        expect_val("ip7_set", OBS_IP7, 32'h1);
        drain();
        mtc0(5'd12, 32'h0040_8001);
        expect_val("timer_intp", OBS_INTP, 32'h1);
        drain();
        mtc0(5'd11, 32'd100);
        expect_val("ti_clr", OBS_TI, 32'h0);
        expect_val("intp_lag", OBS_INTP, 32'h1);
        drain();
        step();
        expect_val("intp_drop", OBS_INTP, 32'h0);
        drain();

        hw_int = 6'b000001;
        mtc0(5'd12, 32'h0040_0401);
        expect_val("hw_intp", OBS_INTP, 32'h1);
        drain();
        mtc0(5'd12, 32'h0040_0403);
        expect_val("hw_exl_mask", OBS_INTP, 32'h0);
        drain();
        mtc0(5'd12, 32'h0040_0001);
        expect_val("hw_im_mask", OBS_INTP, 32'h0);
        drain();
        hw_int = 6'b0;

        mtc0(5'd9, 32'hFFFF_FFFF);
        expect_val("count_load", 6'd9, 32'hFFFF_FFFF);
        drain();
        step();
        expect_val("count_hold", 6'd9, 32'hFFFF_FFFF);
        drain();
        step();
        expect_val("count_wrap", 6'd9, 32'h0);
        drain();

        mtc0(5'd9, 32'h0000_1234);
        #2 rst_n = 1'b0;
        expect_val("mrst_status", OBS_STAT, 32'h0040_0000);
        expect_val("mrst_cause", OBS_CAUSE, 32'h0);
        expect_val("mrst_count", 6'd9, 32'h0);
        expect_val("mrst_epc", OBS_EPC, 32'h0);
        expect_val("mrst_badva", 6'd8, 32'h0);
        drain();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cp0_regfile.md
# cp0_regfile

Coprocessor-0 register file for the MIPS32 pipeline. It holds BadVAddr, Count, Compare, Status, Cause and EPC, and applies the write-enables and values produced by the exception detector. It also serves MFC0/MTC0 and ERET, runs the Count/Compare timer, and drives the pending-interrupt request back to the exception detector. It sits beside the writeback stage; all architectural CP0 state lives here.

## Interface
- No parameters.
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- mtc0_we  in  1  MTC0 write strobe
- mtc0_addr  in  5  CP0 register number for MTC0 (sel fixed 0)
- mtc0_wdata  in  32  MTC0 data
- rd_addr  in  5  CP0 register number for MFC0
- rd_data  out  32  MFC0 read data, combinational from current state
- exc_valid  in  1  exception commit (exception_occur from detector)
- exc_code  in  5  ExcCode to record
- exc_epc  in  32  faulting PC
- exc_bd  in  1  faulting instruction in branch-delay slot
- exc_badvaddr_we  in  1  BadVAddr write enable (we[8] from detector)
- exc_badvaddr  in  32  faulting address
- eret  in  1  ERET commit
- hw_int  in  6  external interrupt lines, level-sensitive
- status  out  32  Status (reg 12)
- cause  out  32  Cause (reg 13)
- epc  out  32  EPC (reg 14), also the ERET target
- int_pending  out  1  unmasked interrupt pending

## Operation
- Address map: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC. Any other rd_addr reads 0; MTC0 to any other address is ignored.
- Status fields:
  - IM[15:8], EXL[1] and IE[0] are writable.
  - BEV[22] is constant 1.
  - All other bits read 0.
- Cause fields:
  - BD[31] and TI[30] are hardware-set.
  - IP[15:10] are hardware-sampled.
  - IP[9:8] are software-writable.
  - ExcCode[6:2] is hardware-written.
  - All other bits read 0.
- Per-edge priority: exc_valid > eret > mtc0_we. A lower-priority action on a conflicting register is dropped. MTC0 to Count or Compare proceeds alongside an exception/ERET; it does not conflict.
- Exception (exc_valid=1):
  - ExcCode <= exc_code.
  - If EXL was 0: EPC <= exc_epc and BD <= exc_bd, then EXL <= 1.
  - If EXL was already 1: EPC and BD are unchanged and EXL stays 1.
  - If exc_badvaddr_we: BadVAddr <= exc_badvaddr.
- ERET (no exception): EXL <= 0. EPC is unchanged.
- Count: increments by 1 every second clock, driven by an internal toggle bit.
  - MTC0 Count loads mtc0_wdata and clears the toggle.
  - Count wraps 0xFFFFFFFF -> 0.
- Timer:
  - On any edge where Count == Compare and no Compare write occurs, TI <= 1 (sticky).
  - MTC0 Compare loads the value and clears TI.
- IP sampling: every edge, IP[15:10] <= {hw_int[5] | TI, hw_int[4:0]}. TI here is the registered value.
- int_pending = |(Cause[15:8] & Status[15:8]) & Status[0] & ~Status[1], combinational from registers.

## Timing
- Reset values (async assert, sync-safe deassert):
  - Status = 0x0040_0000
  - Cause = 0
  - Count = 0, toggle = 0
  - Compare = 0
  - EPC = 0
  - BadVAddr = 0
  - int_pending = 0
- Reset asserted mid-operation overrides all pending writes immediately.
- All writes take effect at the rising edge. rd_data/status/cause/epc reflect new values the cycle after. There is no write-to-read bypass; the pipeline forwards if needed.
- Timer latency:
  - TI sets one edge after the equality cycle.
  - IP7 follows one further edge.
  - int_pending follows combinationally from IP7.
- hw_int to IP latency is 1 edge.
- After reset Count == Compare == 0, so TI sets at the first edge. Software is expected to write Compare before enabling IE.
- A simultaneous exc_valid and eret: the exception wins and EXL stays 1.
- A simultaneous Count==Compare and MTC0 Compare: TI is cleared.

## Test plan
- Reset: drive rst_n=0 mid-run with Count=0x1234 -> Status reads 0x00400000, Cause 0, Count 0, EPC 0 immediately.
- Exception: EXL=0, exc_valid, exc_code=0x04, exc_epc=0xBFC00104, exc_bd=1, badvaddr_we with 0xBFC00101 -> EPC=0xBFC00104, Cause=0x80000010, Status[1]=1, BadVAddr=0xBFC00101. A second exception with code 0x0C while EXL=1 -> EPC unchanged, ExcCode=0x0C.
- ERET and exception in the same cycle -> EXL remains 1. ERET alone next cycle -> EXL=0, epc output unchanged.
- Timer: MTC0 Compare=10, Count=0 -> TI=1 after about 21 clocks, Cause[15]=1 one edge later. With Status=0x00408001, int_pending=1. MTC0 Compare=100 -> TI=0 and int_pending drops within 2 edges.
- Interrupt masking: hw_int=6'b000001, Status=0x00400401 -> int_pending=1. Set EXL -> 0. Clear IM2 -> 0.
- MTC0 masking: write 0xFFFFFFFF to Status -> reads 0x0040FF03. Write 0xFFFFFFFF to Cause -> only IP[9:8] become 1. Write to reg 15 -> ignored, reads 0.
